// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - turns the held-key level into press/repeat/release events
// and queues them in a show-ahead FIFO.
module key_event_fifo #(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ready,
   input  logic [4:0]                 keycode,
   input  logic                       rd_en,
   output logic                       ev_valid,
   output logic [4:0]                 ev_code,
   output logic                       ev_release,
   output logic                       ev_repeat,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   // With REPEAT_DELAY=0 the first target wraps, but rep_hit is gated off anyway.
   localparam logic [31:0] FIRST_TGT = REPEAT_DELAY - 32'd1;
   localparam logic [31:0] NEXT_TGT  = REPEAT_RATE - 32'd1;

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

   state_t      state, state_next;
   logic        r_ready;
   logic [4:0]  r_code;
   logic [4:0]  held_code;
   logic [31:0] cnt;
   logic        first_rep;
   logic        key_gone;
   logic        rep_hit;
   logic        push;
   logic [6:0]  push_ev;

   assign key_gone = !r_ready || (r_code != held_code);
   assign rep_hit  = (REPEAT_DELAY != 0) && (cnt == (first_rep ? FIRST_TGT : NEXT_TGT));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (r_ready)  state_next = HELD;
         HELD:    if (key_gone) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Release wins over repeat when both would fire in the same cycle.
   always_comb begin
      push    = 1'b0;
      push_ev = {r_code, 2'b00};
      case (state)
         IDLE: push = r_ready;
         HELD: begin
            if (key_gone) begin
               push    = 1'b1;
               push_ev = {held_code, 2'b10};
            end else if (rep_hit) begin
               push    = 1'b1;
               push_ev = {held_code, 2'b01};
            end
         end
         default: push = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready   <= 1'b0;
         r_code    <= '0;
         held_code <= '0;
         cnt       <= '0;
         first_rep <= 1'b0;
      end else begin
         r_ready <= ready;
         r_code  <= keycode;
         if (state == IDLE) begin
            if (r_ready) begin
               held_code <= r_code;
               cnt       <= '0;
               first_rep <= 1'b1;
            end
         end else if (!key_gone && REPEAT_DELAY != 0) begin
            if (rep_hit) begin
               cnt       <= '0;
               first_rep <= 1'b0;
            end else begin
               cnt <= cnt + 32'd1;
            end
         end
      end
   end

   logic [6:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          full, do_pop, do_push;

   assign ev_valid = (count != '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = rd_en && ev_valid;
   assign do_push  = push && (!full || do_pop);
   assign {ev_code, ev_release, ev_repeat} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_ev;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
         if (push && full && !do_pop) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_key_event_fifo.sv
// tb/tb_key_event_fifo.sv - randomized bench for key_event_fifo against an
// event-timeline reference model.
module tb_key_event_fifo;
   localparam int DEPTH = 4;
   localparam int RD    = 10;
   localparam int RR    = 4;

   logic       clk = 1'b0, rst = 1'b1, ready = 1'b0, rd_en = 1'b0;
   logic [4:0] keycode = '0;
   logic       ev_valid, ev_release, ev_repeat, overflow;
   logic [4:0] ev_code;
   logic [2:0] count;

   logic       ready0 = 1'b0, rd_en0 = 1'b0;
   logic [4:0] keycode0 = '0;
   logic       ev_valid0, ev_release0, ev_repeat0, overflow0;
   logic [4:0] ev_code0;
   logic [2:0] count0;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   key_event_fifo #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .rst(rst), .ready(ready), .keycode(keycode), .rd_en(rd_en),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_release(ev_release),
      .ev_repeat(ev_repeat), .count(count), .overflow(overflow));

   key_event_fifo #(.DEPTH(DEPTH), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut0 (
      .clk(clk), .rst(rst), .ready(ready0), .keycode(keycode0), .rd_en(rd_en0),
      .ev_valid(ev_valid0), .ev_code(ev_code0), .ev_release(ev_release0),
      .ev_repeat(ev_repeat0), .count(count0), .overflow(overflow0));

   // Model: events are {code, rel, rep}; timing derived from absolute timestamps.
   logic [6:0] q[$];
   bit         m_ovf, m_held, m_r_ready;
   logic [4:0] m_r_code, m_hcode;
   longint     now = 0, next_rep = 0;

   task automatic cycle();
      logic [6:0] e;
      bit have, pop;
      @(posedge clk);
      now++;
      if (rst) begin
         q.delete();
         m_ovf = 0; m_held = 0; m_r_ready = 0; m_r_code = '0;
      end else begin
         have = 0;
         e    = '0;
         if (!m_held) begin
            if (m_r_ready) begin
               have = 1; e = {m_r_code, 2'b00};
               m_held = 1; m_hcode = m_r_code; next_rep = now + RD;
            end
         end else if (!m_r_ready || m_r_code != m_hcode) begin
            have = 1; e = {m_hcode, 2'b10}; m_held = 0;
         end else if (now == next_rep) begin
            have = 1; e = {m_hcode, 2'b01}; next_rep = now + RR;
         end
         pop = rd_en && q.size() > 0;
         if (have && !pop && q.size() == DEPTH) m_ovf = 1;
         if (pop) void'(q.pop_front());
         if (have && q.size() < DEPTH) q.push_back(e);
         m_r_ready = ready;
         m_r_code  = keycode;
      end
      #1;
   endtask

   function automatic bit model_match();
      return (count === 3'(q.size())) && (ev_valid === (q.size() != 0)) &&
             (overflow === m_ovf) &&
             (q.size() == 0 || {ev_code, ev_release, ev_repeat} === q[0]);
   endfunction

   function automatic string state_str();
      return $sformatf("count=%0d/%0d valid=%b/%b head=%h/%h ovf=%b/%b t=%0d",
         count, q.size(), ev_valid, q.size() != 0, {ev_code, ev_release, ev_repeat},
         (q.size() != 0) ? q[0] : 7'h0, overflow, m_ovf, now);
   endfunction

   task automatic apply_reset();
      rst = 1'b1; ready = 1'b0; rd_en = 1'b0; keycode = '0;
      cycle(); cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (ev_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 ||
          ev_code !== 5'd0 || ev_release !== 1'b0 || ev_repeat !== 1'b0) begin
         failures++;
         $display("FAIL reset valid=%b count=%0d ovf=%b head=%h required all zero",
                  ev_valid, count, overflow, {ev_code, ev_release, ev_repeat});
      end
   endtask

   task automatic test_press_release();
      ready = 1'b1; keycode = 5'h05;
      cycle();
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++; $display("FAIL press_latency1 valid=%b required 0", ev_valid);
      end
      cycle();
      checks++;
      if (ev_valid !== 1'b1 || {ev_code, ev_release, ev_repeat} !== 7'h14) begin
         failures++;
         $display("FAIL press_latency2 valid=%b head=%h required 1/14", ev_valid,
                  {ev_code, ev_release, ev_repeat});
      end
      cycle();
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (!model_match()) begin failures++; $display("FAIL press_release %s", state_str()); end
      end
      checks++;
      if (count !== 3'd2 || {ev_code, ev_release, ev_repeat} !== 7'h14) begin
         failures++; $display("FAIL press_release_count count=%0d required 2", count);
      end
      rd_en = 1'b1;
      cycle();
      checks++;
      if (count !== 3'd1 || {ev_code, ev_release, ev_repeat} !== 7'h16) begin
         failures++;
         $display("FAIL release_head count=%0d head=%h required 1/16", count,
                  {ev_code, ev_release, ev_repeat});
      end
      cycle();
      rd_en = 1'b0;
   endtask

   task automatic test_repeat_overflow();
      ready = 1'b1; keycode = 5'h0A;
      for (int i = 0; i < 30; i++) begin
         cycle();
         checks++;
         if (!model_match()) begin failures++; $display("FAIL repeat %s", state_str()); end
      end
      checks++;
      if (count !== 3'd4 || overflow !== 1'b1 || {ev_code, ev_release, ev_repeat} !== 7'h28) begin
         failures++;
         $display("FAIL repeat_overflow count=%0d ovf=%b head=%h required 4/1/28",
                  count, overflow, {ev_code, ev_release, ev_repeat});
      end
   endtask

   task automatic test_reset_mid_hold();
      rst = 1'b1;
      cycle(); cycle();
      checks++;
      if (count !== 3'd0 || overflow !== 1'b0 || ev_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_hold count=%0d ovf=%b valid=%b required 0/0/0",
                  count, overflow, ev_valid);
      end
      rst = 1'b0;
      cycle();
      checks++;
      if (ev_valid !== 1'b0) begin
         failures++; $display("FAIL rst_repress1 valid=%b required 0", ev_valid);
      end
      cycle();
      checks++;
      if (ev_valid !== 1'b1 || {ev_code, ev_release, ev_repeat} !== 7'h28) begin
         failures++;
         $display("FAIL rst_repress2 valid=%b head=%h required 1/28", ev_valid,
                  {ev_code, ev_release, ev_repeat});
      end
      apply_reset();
   endtask

   task automatic test_empty_pop();
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (count !== 3'd0 || ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_pop count=%0d valid=%b required 0/0", count, ev_valid);
         end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_key_change();
      ready = 1'b1; keycode = 5'h03;
      for (int i = 0; i < 4; i++) cycle();
      keycode = 5'h11;
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (!model_match()) begin failures++; $display("FAIL key_change %s", state_str()); end
      end
      checks++;
      if (count !== 3'd3 || q.size() != 3 || q[1] !== 7'h0E || q[2] !== 7'h44) begin
         failures++;
         $display("FAIL key_change_seq count=%0d required 3 (press03,rel03,press11)", count);
      end
      ready = 1'b0;
      apply_reset();
   endtask

   task automatic test_back_to_back();
      rd_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            ready   = $urandom_range(0, 1);
            keycode = 5'($urandom_range(0, 31));
         end
         cycle();
         checks++;
         if (!model_match() || count > 3'd1 || overflow !== 1'b0) begin
            failures++; $display("FAIL back_to_back %s", state_str());
         end
      end
      rd_en = 1'b0; ready = 1'b0;
      apply_reset();
   endtask

   task automatic test_random();
      int len;
      for (int seg = 0; seg < 40; seg++) begin
         ready   = $urandom_range(0, 4) != 0;
         keycode = 5'($urandom_range(0, 31));
         len     = $urandom_range(1, 25);
         for (int i = 0; i < len; i++) begin
            rd_en = $urandom_range(0, 2) == 0;
            cycle();
            checks++;
            if (!model_match()) begin failures++; $display("FAIL random %s", state_str()); end
         end
      end
      rd_en = 1'b0; ready = 1'b0;
   endtask

   task automatic test_no_repeat();
      int maxc = 0;
      ready0 = 1'b1; keycode0 = 5'h07;
      for (int i = 0; i < 100; i++) begin
         cycle();
         if (int'(count0) > maxc) maxc = int'(count0);
      end
      ready0 = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if (maxc != 1 || count0 !== 3'd2 || overflow0 !== 1'b0 ||
          {ev_code0, ev_release0, ev_repeat0} !== 7'h1C) begin
         failures++;
         $display("FAIL no_repeat max=%0d count=%0d ovf=%b head=%h required 1/2/0/1c",
                  maxc, count0, overflow0, {ev_code0, ev_release0, ev_repeat0});
      end
      rd_en0 = 1'b1;
      cycle();
      rd_en0 = 1'b0;
      checks++;
      if (count0 !== 3'd1 || {ev_code0, ev_release0, ev_repeat0} !== 7'h1E) begin
         failures++;
         $display("FAIL no_repeat_release count=%0d head=%h required 1/1e", count0,
                  {ev_code0, ev_release0, ev_repeat0});
      end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_repeat_overflow();
      test_reset_mid_hold();
      test_empty_pop();
      test_key_change();
      test_back_to_back();
      test_random();
      test_no_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t required completion", $time);
      $fatal(1, "timeout");
   end
endmodule
